// File: rtl/amba_axi4_lite_regfile_subordinate.sv
// AXI4-Lite subordinate backed by a small register file.
// The write path uses one holding register per channel (AW, W), so the two
// channels can arrive in either order. A write commits once both are held
// and no write response is pending. The read path answers in the same edge
// as the AR handshake and then holds R until the manager takes it.
module amba_axi4_lite_regfile_subordinate #(
  parameter int unsigned                  ADDRESS_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH    = 32,
  parameter int unsigned                  NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0]     BASE_ADDR     = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [ADDRESS_WIDTH-1:0] AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [DATA_WIDTH/8-1:0]  WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDRESS_WIDTH-1:0] ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned LANE_W     = $clog2(STRB_WIDTH);
  // Size of the decoded window in bytes.
  localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(NUM_REGS * STRB_WIDTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Protection attributes are accepted but carry no meaning here.
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  // Reset-release tracking: no READY is offered until one clean edge has passed.
  logic rst_done_q;

  // Write-path state.
  logic                     aw_full_q, aw_full_d;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                     w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0]    w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0]    w_strb_q,  w_strb_d;
  logic                     bvalid_q,  bvalid_d;
  logic [1:0]               bresp_q,   bresp_d;

  // Read-path state.
  logic                     rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q,   rdata_d;
  logic [1:0]               rresp_q,   rresp_d;

  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];

  // Address decode for the held write address and the live read address.
  logic [ADDRESS_WIDTH-1:0] wr_off, rd_off;
  logic                     wr_hit, rd_hit;
  logic [IDX_W-1:0]         wr_idx, rd_idx;

  assign wr_off = aw_addr_q - BASE_ADDR;
  assign rd_off = ARADDR - BASE_ADDR;
  assign wr_hit = (aw_addr_q >= BASE_ADDR) && (wr_off < SPAN);
  assign rd_hit = (ARADDR >= BASE_ADDR) && (rd_off < SPAN);
  assign wr_idx = wr_off[LANE_W +: IDX_W];
  assign rd_idx = rd_off[LANE_W +: IDX_W];

  // READYs depend only on internal flops.
  assign AWREADY = rst_done_q & ~aw_full_q;
  assign WREADY  = rst_done_q & ~w_full_q;
  assign ARREADY = rst_done_q & ~rvalid_q;

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  logic aw_hs, w_hs, ar_hs, commit;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  // A write retires only when both halves are held and B is free.
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  // Write-path next state: capture AW/W, commit, and B handshake.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end
    // A handshake cannot coincide with commit: READY is low while a slot is full.
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
  end

  // Read-path next state: the response is formed on the AR handshake edge.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Channel state registers; reset drops anything in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rst_done_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // One register per index; only strobed byte lanes change on a hitting commit.
  // A read on the same edge sees the old contents since both update together.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        regs_q[gi] <= '0;
      end else if (commit && wr_hit && (wr_idx == IDX_W'(gi))) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (w_strb_q[b]) begin
            regs_q[gi][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_amba_axi4_lite_regfile_subordinate.sv
// Directed bench for the AXI4-Lite register-file subordinate (default parameters).
module tb_amba_axi4_lite_regfile_subordinate;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int tests = 0;
  int fails = 0;

  amba_axi4_lite_regfile_subordinate dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Issue one read and return the captured response.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    ARADDR = addr;
    ARVALID = 1'b1;
    RREADY = 1'b0;
    n = 0;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    if (!ARREADY) begin
      tests++;
      fails++;
      $display("FAIL read_timeout addr=%h: ARREADY=%b required 1", addr, ARREADY);
    end
    tick();
    ARVALID = 1'b0;
    data = RDATA;
    resp = RRESP;
    $display("[TB] read  addr=%h data=%h resp=%b", addr, data, resp);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  // Issue one write with AW and W presented together, return BRESP.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    AWADDR = addr;
    AWVALID = 1'b1;
    WDATA = data;
    WSTRB = strb;
    WVALID = 1'b1;
    BREADY = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      aw_hs = AWVALID && AWREADY;
      w_hs = WVALID && WREADY;
      tick();
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs) WVALID = 1'b0;
      n++;
    end
    n = 0;
    while (!BVALID && n < 20) begin
      tick();
      n++;
    end
    if (!BVALID) begin
      tests++;
      fails++;
      $display("FAIL write_timeout addr=%h: BVALID=%b required 1", addr, BVALID);
    end
    resp = BRESP;
    $display("[TB] write addr=%h data=%h strb=%b resp=%b", addr, data, strb, resp);
    tick();
    BREADY = 1'b0;
    AWVALID = 1'b0;
    WVALID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_held: rdy/valid=%b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    tests++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      fails++;
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h required 0", BRESP, RRESP, RDATA);
    end
    ARESETn = 1'b1;
    #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      fails++;
      $display("FAIL reset_first_cycle: ready=%b required 000", {AWREADY, WREADY, ARREADY});
    end
    tick();
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      fails++;
      $display("FAIL reset_release: rdy/valid=%b required 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    $display("[TB] reset released");
  endtask

  task automatic test_write_same_cycle();
    logic [31:0] d;
    logic [1:0] r;
    AWADDR = 32'h8;
    WDATA = 32'hDEADBEEF;
    WSTRB = 4'hF;
    AWVALID = 1'b1;
    WVALID = 1'b1;
    BREADY = 1'b0;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b0;
    tests++;
    if (BVALID !== 1'b0) begin
      fails++;
      $display("FAIL wr_latency_early: BVALID=%b required 0", BVALID);
    end
    tick();
    tests++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      fails++;
      $display("FAIL wr_bresp: BVALID=%b BRESP=%b required 1/00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    tests++;
    if (BVALID !== 1'b0) begin
      fails++;
      $display("FAIL wr_b_clear: BVALID=%b required 0", BVALID);
    end
    $display("[TB] write addr=00000008 data=deadbeef strb=1111 same-cycle");
    do_read(32'h8, d, r);
    tests++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      fails++;
      $display("FAIL rd_after_wr: RDATA=%h RRESP=%b required deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_first_stall();
    logic [31:0] d;
    logic [1:0] r;
    WDATA = 32'h000000AA;
    WSTRB = 4'h1;
    WVALID = 1'b1;
    BREADY = 1'b0;
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
        fails++;
        $display("FAIL w_held_%0d: WREADY=%b BVALID=%b required 0/0", i, WREADY, BVALID);
      end
      tick();
    end
    AWADDR = 32'h8;
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
        fails++;
        $display("FAIL b_stall_%0d: BVALID=%b BRESP=%b required 1/00", i, BVALID, BRESP);
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    tests++;
    if (BVALID !== 1'b0) begin
      fails++;
      $display("FAIL b_stall_clear: BVALID=%b required 0", BVALID);
    end
    $display("[TB] write addr=00000008 data=000000aa strb=0001 w-first stalled-B");
    do_read(32'h8, d, r);
    tests++;
    if (d !== 32'hDEADBEAA || r !== 2'b00) begin
      fails++;
      $display("FAIL strobe_merge: RDATA=%h RRESP=%b required deadbeaa/00", d, r);
    end
  endtask

  task automatic test_decode_miss();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h40, 32'h12345678, 4'hF, r);
    tests++;
    if (r !== 2'b10) begin
      fails++;
      $display("FAIL miss_bresp: BRESP=%b required 10", r);
    end
    do_read(32'h40, d, r);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin
      fails++;
      $display("FAIL miss_read: RDATA=%h RRESP=%b required 00000000/10", d, r);
    end
    do_read(32'h0, d, r);
    tests++;
    if (d !== 32'h0 || r !== 2'b00) begin
      fails++;
      $display("FAIL miss_no_alias: RDATA=%h RRESP=%b required 00000000/00", d, r);
    end
    do_read(32'h8, d, r);
    tests++;
    if (d !== 32'hDEADBEAA) begin
      fails++;
      $display("FAIL miss_no_update: RDATA=%h required deadbeaa", d);
    end
  endtask

  task automatic test_same_edge_rw();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h4, 32'h55AA55AA, 4'hF, r);
    AWADDR = 32'h4;
    WDATA = 32'h11111111;
    WSTRB = 4'hF;
    AWVALID = 1'b1;
    WVALID = 1'b1;
    BREADY = 1'b0;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b0;
    ARADDR = 32'h4;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    tests++;
    if (RVALID !== 1'b1 || RDATA !== 32'h55AA55AA || BVALID !== 1'b1) begin
      fails++;
      $display("FAIL same_edge_old: RVALID=%b RDATA=%h BVALID=%b required 1/55aa55aa/1", RVALID, RDATA, BVALID);
    end
    $display("[TB] same-edge read addr=00000004 data=%h", RDATA);
    RREADY = 1'b1;
    BREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    BREADY = 1'b0;
    do_read(32'h4, d, r);
    tests++;
    if (d !== 32'h11111111 || r !== 2'b00) begin
      fails++;
      $display("FAIL same_edge_new: RDATA=%h RRESP=%b required 11111111/00", d, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0] r;
    ARADDR = 32'h8;
    ARVALID = 1'b1;
    RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    tests++;
    if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEAA) begin
      fails++;
      $display("FAIL mid_pre: RVALID=%b RDATA=%h required 1/deadbeaa", RVALID, RDATA);
    end
    #2;
    ARESETn = 1'b0;
    #1;
    tests++;
    if (RVALID !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: RVALID=%b RDATA=%h ARREADY=%b required 0/00000000/0", RVALID, RDATA, ARREADY);
    end
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    tests++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_resp: RVALID=%b BVALID=%b required 0/0", RVALID, BVALID);
    end
    $display("[TB] reset asserted mid-read and released");
    do_read(32'h8, d, r);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL mid_reg8_cleared: RDATA=%h required 00000000", d);
    end
    do_read(32'h4, d, r);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL mid_reg4_cleared: RDATA=%h required 00000000", d);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write_same_cycle();
    test_w_first_stall();
    test_decode_miss();
    test_same_edge_rw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
